// File: rtl/commit_buffer_pkg.sv
// Shared bus types and constants for the in-order commit buffer.
package commit_buffer_pkg;

  localparam int COMMIT_DEPTH = 32;
  localparam int XLEN = 32;
  localparam int PC_W = 16;

  localparam logic RESULT_KIND_WB    = 1'b1;
  localparam logic ENTRY_KIND_BRANCH = 1'b1;

  typedef struct packed {
    logic            kind;        // 0 = wb, 1 = branch
    logic            fin;
    logic [4:0]      dest_logic;
    logic [1:0]      notify;      // [0] uart, [1] sw
    logic [PC_W-1:0] current_pc;
    logic [XLEN-1:0] data;
    logic            raise;
    logic            taken;
    logic [PC_W-1:0] new_pc;
  } commit_entry_t;

  typedef struct packed {
    logic            en;
    logic            kind;        // 1 = wb, 0 = branch
    logic [7:0]      commit_id;
    logic [XLEN-1:0] data;
    logic            raise;
    logic            taken;
    logic [PC_W-1:0] new_pc;
  } result_t;

  typedef struct packed {
    logic            en;
    logic [4:0]      dest_logic;
    logic [XLEN-1:0] data;
  } commit_info_t;

  typedef struct packed {
    logic        en;
    logic        miss;
    logic        taken;
    logic [31:0] current_pc;
    logic [31:0] jump_addr;
  } branch_result_t;

  // The two kind fields use opposite encodings; a Result only lands on an entry of the same class.
  function automatic logic kinds_match(input logic entry_kind, input logic result_kind);
    return (result_kind == RESULT_KIND_WB) == (entry_kind != ENTRY_KIND_BRANCH);
  endfunction

endpackage

// File: rtl/commit_ring_ctrl.sv
// Head/tail/occupancy bookkeeping for the commit ring; a flush empties the ring on the same edge.
module commit_ring_ctrl #(
  parameter int DEPTH = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic             retire_i,
  input  logic             flush_i,
  output logic [PTR_W-1:0] head_o,
  output logic [PTR_W-1:0] tail_o,
  output logic             full_o
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (retire_i) head_d = head_q + 1'b1;
      if (push_i)   tail_d = tail_q + 1'b1;
      case ({push_i, retire_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o = head_q;
  assign tail_o = tail_q;
  assign full_o = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/commit_buffer.sv
// In-order reorder buffer: allocates commit ids, absorbs out-of-order results,
// retires one finished head entry per cycle and flushes on a mispredicted branch.
module commit_buffer
  import commit_buffer_pkg::*;
#(
  parameter int DEPTH = COMMIT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           push_en_i,
  input  commit_entry_t  push_entry_i,
  output logic [7:0]     push_commit_id_o,
  output logic           full_o,
  input  result_t        result_i,
  output commit_info_t   commit_o,
  output branch_result_t branch_result_o,
  output logic [1:0]     notify_o,
  output logic           flush_o
);

  logic [PTR_W-1:0] head, tail;
  logic             full;
  commit_entry_t    entry_q [DEPTH];
  commit_entry_t    head_entry;
  logic [DEPTH-1:0] valid_q, valid_d, fin_q, fin_d;
  logic             retire, mispredict, push_acc, res_hit;
  logic [PTR_W-1:0] res_idx;
  logic             unused_bits;

  assign head_entry = entry_q[head];
  assign retire     = valid_q[head] & fin_q[head];
  assign mispredict = retire && (head_entry.kind == ENTRY_KIND_BRANCH) && head_entry.raise;
  assign push_acc   = push_en_i && !full;
  assign res_idx    = result_i.commit_id[PTR_W-1:0];
  assign res_hit    = result_i.en && valid_q[res_idx] && !mispredict &&
                      kinds_match(entry_q[res_idx].kind, result_i.kind);

  // Bits that carry no information for this buffer (id padding, stored fin copy).
  assign unused_bits = ^{result_i.commit_id, head_entry.fin};

  commit_ring_ctrl #(.DEPTH(DEPTH)) u_ring (
    .clk      (clk),
    .rstn     (rstn),
    .push_i   (push_acc),
    .retire_i (retire),
    .flush_i  (mispredict),
    .head_o   (head),
    .tail_o   (tail),
    .full_o   (full)
  );

  // A free tail slot is never the target of a live result, so push and result never collide.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign valid_d[gi] = mispredict                            ? 1'b0 :
                         (push_acc && tail == PTR_W'(gi))      ? 1'b1 :
                         (retire && head == PTR_W'(gi))        ? 1'b0 : valid_q[gi];
    assign fin_d[gi]   = mispredict                            ? 1'b0 :
                         (push_acc && tail == PTR_W'(gi))      ? push_entry_i.fin :
                         (res_hit && res_idx == PTR_W'(gi))    ? 1'b1 : fin_q[gi];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      fin_q   <= '0;
    end else begin
      valid_q <= valid_d;
      fin_q   <= fin_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) entry_q[tail] <= push_entry_i;
    if (res_hit) begin
      if (result_i.kind == RESULT_KIND_WB) begin
        entry_q[res_idx].data <= result_i.data;
      end else begin
        entry_q[res_idx].raise  <= result_i.raise;
        entry_q[res_idx].taken  <= result_i.taken;
        entry_q[res_idx].new_pc <= result_i.new_pc;
      end
    end
  end

  commit_info_t   commit_d;
  branch_result_t branch_d;
  logic [1:0]     notify_d;
  logic           flush_d;

  always_comb begin
    commit_d = '0;
    branch_d = '0;
    notify_d = '0;
    flush_d  = 1'b0;
    if (retire) begin
      if (head_entry.kind == ENTRY_KIND_BRANCH) begin
        branch_d.en         = 1'b1;
        branch_d.miss       = head_entry.raise;
        branch_d.taken      = head_entry.taken;
        branch_d.current_pc = 32'(head_entry.current_pc);
        branch_d.jump_addr  = 32'(head_entry.new_pc);
        flush_d             = head_entry.raise;
      end else begin
        commit_d.en         = 1'b1;
        commit_d.dest_logic = head_entry.dest_logic;
        commit_d.data       = head_entry.data;
        notify_d            = head_entry.notify;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      commit_o        <= '0;
      branch_result_o <= '0;
      notify_o        <= '0;
      flush_o         <= 1'b0;
    end else begin
      commit_o        <= commit_d;
      branch_result_o <= branch_d;
      notify_o        <= notify_d;
      flush_o         <= flush_d;
    end
  end

  assign push_commit_id_o = 8'(tail);
  assign full_o           = full;

endmodule
